reorder_buffer: RTL and testbench

Circular 16-entry reorder buffer of the out-of-order RISC-V core. It sits between the decoder/issue stage and the architectural register file. Entries are allocated in program order at issue and filled out of order by the ALU and LSB result buses. Entries retire in order from the head, producing register-file commits, store releases, predictor updates and mispredict rollbacks.

---
 rtl/rob_if.sv | 62 ++++++
 rtl/reorder_buffer.sv | 196 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Bundle of the reorder buffer's issue, query, writeback and commit signals.
// The ROB itself connects through the slave view.
interface rob_if #(parameter int ROB_POS_W = 4);
    logic                 rdy;
    logic                 rob_full;
    logic                 issue;
    logic [1:0]           issue_type;
    logic [4:0]           issue_rd;
    logic [31:0]          issue_pc;
    logic                 issue_pred_jump;
    logic                 issue_ready;
    logic [31:0]          issue_val;
    logic [ROB_POS_W-1:0] issue_rob_pos;
    logic [ROB_POS_W-1:0] query_pos1;
    logic [ROB_POS_W-1:0] query_pos2;
    logic                 query_ready1;
    logic                 query_ready2;
    logic [31:0]          query_val1;
    logic [31:0]          query_val2;
    logic                 alu_result;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [31:0]          alu_val;
    logic                 alu_jump;
    logic [31:0]          alu_pc;
    logic                 lsb_result;
    logic [ROB_POS_W-1:0] lsb_rob_pos;
    logic [31:0]          lsb_val;
    logic                 rob_commit;
    logic [4:0]           rob_commit_rd;
    logic [31:0]          rob_commit_val;
    logic [ROB_POS_W-1:0] rob_commit_rob_pos;
    logic                 store_commit;
    logic [ROB_POS_W-1:0] store_rob_pos;
    logic                 br_commit;
    logic [31:0]          br_pc;
    logic                 br_taken;
    logic                 rollback;
    logic                 set_pc_en;
    logic [31:0]          set_pc;

    modport slave (
        input  rdy, issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
               issue_ready, issue_val, query_pos1, query_pos2,
               alu_result, alu_rob_pos, alu_val, alu_jump, alu_pc,
               lsb_result, lsb_rob_pos, lsb_val,
        output rob_full, issue_rob_pos, query_ready1, query_ready2,
               query_val1, query_val2, rob_commit, rob_commit_rd,
               rob_commit_val, rob_commit_rob_pos, store_commit, store_rob_pos,
               br_commit, br_pc, br_taken, rollback, set_pc_en, set_pc
    );

    modport master (
        output rdy, issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
               issue_ready, issue_val, query_pos1, query_pos2,
               alu_result, alu_rob_pos, alu_val, alu_jump, alu_pc,
               lsb_result, lsb_rob_pos, lsb_val,
        input  rob_full, issue_rob_pos, query_ready1, query_ready2,
               query_val1, query_val2, rob_commit, rob_commit_rd,
               rob_commit_val, rob_commit_rob_pos, store_commit, store_rob_pos,
               br_commit, br_pc, br_taken, rollback, set_pc_en, set_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback,
// in-order retirement with registered commit, store, branch and rollback pulses.
module reorder_buffer #(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_POS_W = 4
) (
    input  logic   clk,
    input  logic   rst,
    rob_if.slave   rob
);
    localparam int CW = ROB_POS_W + 1;

    typedef enum logic [1:0] {T_REG = 2'd0, T_BR = 2'd1, T_ST = 2'd2, T_JALR = 2'd3} rob_type_e;

    logic                 busy_q   [ROB_SIZE];
    logic                 ready_q  [ROB_SIZE];
    rob_type_e            type_q   [ROB_SIZE];
    logic [4:0]           rd_q     [ROB_SIZE];
    logic [31:0]          pc_q     [ROB_SIZE];
    logic                 pred_q   [ROB_SIZE];
    logic                 jump_q   [ROB_SIZE];
    logic [31:0]          target_q [ROB_SIZE];
    logic [31:0]          val_q    [ROB_SIZE];
    logic [ROB_POS_W-1:0] head_q, tail_q;
    logic [CW-1:0]        count_q;

    logic                 rob_commit_q, store_commit_q, br_commit_q, br_taken_q;
    logic                 rollback_q, set_pc_en_q;
    logic [4:0]           rob_commit_rd_q;
    logic [31:0]          rob_commit_val_q, br_pc_q, set_pc_q;
    logic [ROB_POS_W-1:0] rob_commit_rob_pos_q, store_rob_pos_q;

    logic      head_ready, mispredict, flush, accept, do_issue;
    rob_type_e head_type;

    always_comb begin
        head_ready = (count_q != '0) && ready_q[head_q];
        head_type  = type_q[head_q];
        mispredict = (head_type == T_BR) && (jump_q[head_q] != pred_q[head_q]);
        flush      = head_ready && ((head_type == T_JALR) || mispredict);
        // the cycle after a flush, every unit is still draining stale traffic
        accept     = !rollback_q;
        do_issue   = accept && rob.issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                type_q[i]   <= T_REG;
                rd_q[i]     <= '0;
                pc_q[i]     <= '0;
                pred_q[i]   <= 1'b0;
                jump_q[i]   <= 1'b0;
                target_q[i] <= '0;
                val_q[i]    <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rob.rdy) begin
            if (flush) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (accept && rob.alu_result) begin
                    ready_q[rob.alu_rob_pos]  <= 1'b1;
                    val_q[rob.alu_rob_pos]    <= rob.alu_val;
                    jump_q[rob.alu_rob_pos]   <= rob.alu_jump;
                    target_q[rob.alu_rob_pos] <= rob.alu_pc;
                end
                if (accept && rob.lsb_result) begin
                    ready_q[rob.lsb_rob_pos] <= 1'b1;
                    val_q[rob.lsb_rob_pos]   <= rob.lsb_val;
                end
                if (head_ready) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= head_q + ROB_POS_W'(1);
                end
                if (do_issue) begin
                    busy_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]  <= rob.issue_ready;
                    type_q[tail_q]   <= rob_type_e'(rob.issue_type);
                    rd_q[tail_q]     <= rob.issue_rd;
                    pc_q[tail_q]     <= rob.issue_pc;
                    pred_q[tail_q]   <= rob.issue_pred_jump;
                    jump_q[tail_q]   <= 1'b0;
                    target_q[tail_q] <= '0;
                    val_q[tail_q]    <= rob.issue_val;
                    tail_q           <= tail_q + ROB_POS_W'(1);
                end
                count_q <= count_q + CW'(do_issue) - CW'(head_ready);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rob_commit_q         <= 1'b0;
            rob_commit_rd_q      <= '0;
            rob_commit_val_q     <= '0;
            rob_commit_rob_pos_q <= '0;
            store_commit_q       <= 1'b0;
            store_rob_pos_q      <= '0;
            br_commit_q          <= 1'b0;
            br_pc_q              <= '0;
            br_taken_q           <= 1'b0;
            rollback_q           <= 1'b0;
            set_pc_en_q          <= 1'b0;
            set_pc_q             <= '0;
        end else if (rob.rdy) begin
            rob_commit_q   <= 1'b0;
            store_commit_q <= 1'b0;
            br_commit_q    <= 1'b0;
            rollback_q     <= 1'b0;
            set_pc_en_q    <= 1'b0;
            if (head_ready) begin
                case (head_type)
                    T_REG: begin
                        rob_commit_q         <= 1'b1;
                        rob_commit_rd_q      <= rd_q[head_q];
                        rob_commit_val_q     <= val_q[head_q];
                        rob_commit_rob_pos_q <= head_q;
                    end
                    T_ST: begin
                        store_commit_q  <= 1'b1;
                        store_rob_pos_q <= head_q;
                    end
                    T_BR: begin
                        br_commit_q <= 1'b1;
                        br_pc_q     <= pc_q[head_q];
                        br_taken_q  <= jump_q[head_q];
                        if (mispredict) begin
                            rollback_q  <= 1'b1;
                            set_pc_en_q <= 1'b1;
                            set_pc_q    <= jump_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
                        end
                    end
                    T_JALR: begin
                        // link value comes from the entry's own pc, not the broadcast
                        rob_commit_q         <= 1'b1;
                        rob_commit_rd_q      <= rd_q[head_q];
                        rob_commit_val_q     <= pc_q[head_q] + 32'd4;
                        rob_commit_rob_pos_q <= head_q;
                        rollback_q           <= 1'b1;
                        set_pc_en_q          <= 1'b1;
                        set_pc_q             <= target_q[head_q];
                    end
                endcase
            end
        end
    end

    always_comb begin
        rob.query_ready1 = busy_q[rob.query_pos1] && ready_q[rob.query_pos1];
        rob.query_val1   = val_q[rob.query_pos1];
        if (rob.alu_result && rob.alu_rob_pos == rob.query_pos1) begin
            rob.query_ready1 = 1'b1;
            rob.query_val1   = rob.alu_val;
        end else if (rob.lsb_result && rob.lsb_rob_pos == rob.query_pos1) begin
            rob.query_ready1 = 1'b1;
            rob.query_val1   = rob.lsb_val;
        end
        rob.query_ready2 = busy_q[rob.query_pos2] && ready_q[rob.query_pos2];
        rob.query_val2   = val_q[rob.query_pos2];
        if (rob.alu_result && rob.alu_rob_pos == rob.query_pos2) begin
            rob.query_ready2 = 1'b1;
            rob.query_val2   = rob.alu_val;
        end else if (rob.lsb_result && rob.lsb_rob_pos == rob.query_pos2) begin
            rob.query_ready2 = 1'b1;
            rob.query_val2   = rob.lsb_val;
        end
    end

    assign rob.rob_full           = count_q >= CW'(ROB_SIZE - 1);
    assign rob.issue_rob_pos      = tail_q;
    assign rob.rob_commit         = rob_commit_q;
    assign rob.rob_commit_rd      = rob_commit_rd_q;
    assign rob.rob_commit_val     = rob_commit_val_q;
    assign rob.rob_commit_rob_pos = rob_commit_rob_pos_q;
    assign rob.store_commit       = store_commit_q;
    assign rob.store_rob_pos      = store_rob_pos_q;
    assign rob.br_commit          = br_commit_q;
    assign rob.br_pc              = br_pc_q;
    assign rob.br_taken           = br_taken_q;
    assign rob.rollback           = rollback_q;
    assign rob.set_pc_en          = set_pc_en_q;
    assign rob.set_pc             = set_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commit paths, ordering, rollback, wrap,
// query bypass and rdy freeze, each against hand-computed values.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    rob_if #(.ROB_POS_W(4)) rob_bus ();

    reorder_buffer #(.ROB_SIZE(16), .ROB_POS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rob_bus.rdy             = 1'b1;
        rob_bus.issue           = 1'b0;
        rob_bus.issue_type      = 2'd0;
        rob_bus.issue_rd        = 5'd0;
        rob_bus.issue_pc        = 32'd0;
        rob_bus.issue_pred_jump = 1'b0;
        rob_bus.issue_ready     = 1'b0;
        rob_bus.issue_val       = 32'd0;
        rob_bus.query_pos1      = 4'd0;
        rob_bus.query_pos2      = 4'd0;
        rob_bus.alu_result      = 1'b0;
        rob_bus.alu_rob_pos     = 4'd0;
        rob_bus.alu_val         = 32'd0;
        rob_bus.alu_jump        = 1'b0;
        rob_bus.alu_pc          = 32'd0;
        rob_bus.lsb_result      = 1'b0;
        rob_bus.lsb_rob_pos     = 4'd0;
        rob_bus.lsb_val         = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue_one(input logic [1:0] typ, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pred, input logic rdy_now, input logic [31:0] val);
        rob_bus.issue           = 1'b1;
        rob_bus.issue_type      = typ;
        rob_bus.issue_rd        = rd;
        rob_bus.issue_pc        = pc;
        rob_bus.issue_pred_jump = pred;
        rob_bus.issue_ready     = rdy_now;
        rob_bus.issue_val       = val;
        step();
        rob_bus.issue = 1'b0;
    endtask

    task automatic alu_wb(input logic [3:0] pos, input logic [31:0] val, input logic jmp, input logic [31:0] tgt);
        rob_bus.alu_result  = 1'b1;
        rob_bus.alu_rob_pos = pos;
        rob_bus.alu_val     = val;
        rob_bus.alu_jump    = jmp;
        rob_bus.alu_pc      = tgt;
        step();
        rob_bus.alu_result = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_full",     32'(rob_bus.rob_full), 32'd0);
        chk("rst_tail",     32'(rob_bus.issue_rob_pos), 32'd0);
        chk("rst_commit",   32'(rob_bus.rob_commit), 32'd0);
        chk("rst_rollback", 32'(rob_bus.rollback), 32'd0);
        chk("rst_count",    32'(dut.count_q), 32'd0);

        // fastest path: ready at issue, commit one edge later, one-cycle pulse
        issue_one(2'd0, 5'd5, 32'h0, 1'b0, 1'b1, 32'h1234);
        chk("fast_early", 32'(rob_bus.rob_commit), 32'd0);
        step();
        chk("fast_commit", 32'(rob_bus.rob_commit), 32'd1);
        chk("fast_rd",     32'(rob_bus.rob_commit_rd), 32'd5);
        chk("fast_val",    rob_bus.rob_commit_val, 32'h1234);
        chk("fast_pos",    32'(rob_bus.rob_commit_rob_pos), 32'd0);
        step();
        chk("fast_drop",   32'(rob_bus.rob_commit), 32'd0);

        // out-of-order writeback, in-order commit
        do_reset();
        issue_one(2'd0, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0);
        issue_one(2'd0, 5'd2, 32'h4, 1'b0, 1'b0, 32'h0);
        alu_wb(4'd1, 32'd7, 1'b0, 32'h0);
        chk("ooo_wait", 32'(rob_bus.rob_commit), 32'd0);
        alu_wb(4'd0, 32'd3, 1'b0, 32'h0);
        step();
        chk("ooo_c0",     32'(rob_bus.rob_commit), 32'd1);
        chk("ooo_c0_val", rob_bus.rob_commit_val, 32'd3);
        chk("ooo_c0_pos", 32'(rob_bus.rob_commit_rob_pos), 32'd0);
        step();
        chk("ooo_c1",     32'(rob_bus.rob_commit), 32'd1);
        chk("ooo_c1_val", rob_bus.rob_commit_val, 32'd7);
        chk("ooo_c1_rd",  32'(rob_bus.rob_commit_rd), 32'd2);
        step();
        chk("ooo_done",   32'(rob_bus.rob_commit), 32'd0);

        // query bypass with ALU precedence over LSB
        do_reset();
        for (int i = 0; i < 3; i++) issue_one(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 1'b0, 32'h0);
        rob_bus.query_pos1  = 4'd2;
        rob_bus.query_pos2  = 4'd1;
        rob_bus.alu_result  = 1'b1;
        rob_bus.alu_rob_pos = 4'd2;
        rob_bus.alu_val     = 32'hdead;
        rob_bus.lsb_result  = 1'b1;
        rob_bus.lsb_rob_pos = 4'd2;
        rob_bus.lsb_val     = 32'hbeef;
        #1;
        chk("qry_rdy_alu", 32'(rob_bus.query_ready1), 32'd1);
        chk("qry_val_alu", rob_bus.query_val1, 32'hdead);
        chk("qry_other",   32'(rob_bus.query_ready2), 32'd0);
        rob_bus.alu_result = 1'b0;
        #1;
        chk("qry_val_lsb", rob_bus.query_val1, 32'hbeef);
        rob_bus.lsb_result = 1'b0;
        #1;
        chk("qry_none",    32'(rob_bus.query_ready1), 32'd0);

        // taken branch predicted not-taken: rollback, younger entries dropped
        do_reset();
        issue_one(2'd1, 5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) issue_one(2'd0, 5'(i + 3), 32'h104 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
        alu_wb(4'd0, 32'h0, 1'b1, 32'h200);
        step();
        chk("br_rollback", 32'(rob_bus.rollback), 32'd1);
        chk("br_setpc_en", 32'(rob_bus.set_pc_en), 32'd1);
        chk("br_setpc",    rob_bus.set_pc, 32'h200);
        chk("br_commit",   32'(rob_bus.br_commit), 32'd1);
        chk("br_taken",    32'(rob_bus.br_taken), 32'd1);
        chk("br_pc",       rob_bus.br_pc, 32'h100);
        chk("br_count",    32'(dut.count_q), 32'd0);
        chk("br_tail",     32'(rob_bus.issue_rob_pos), 32'd0);
        // issue during the rollback cycle must be ignored
        rob_bus.issue      = 1'b1;
        rob_bus.issue_type = 2'd0;
        step();
        rob_bus.issue = 1'b0;
        chk("br_rb_drop",   32'(rob_bus.rollback), 32'd0);
        chk("br_ign_tail",  32'(rob_bus.issue_rob_pos), 32'd0);
        chk("br_ign_count", 32'(dut.count_q), 32'd0);

        // store release and a correctly predicted branch
        do_reset();
        issue_one(2'd2, 5'd0, 32'h10, 1'b0, 1'b0, 32'h0);
        issue_one(2'd1, 5'd0, 32'h14, 1'b1, 1'b0, 32'h0);
        rob_bus.lsb_result  = 1'b1;
        rob_bus.lsb_rob_pos = 4'd0;
        rob_bus.lsb_val     = 32'h0;
        alu_wb(4'd1, 32'h0, 1'b1, 32'h300);
        rob_bus.lsb_result = 1'b0;
        step();
        chk("st_commit", 32'(rob_bus.store_commit), 32'd1);
        chk("st_pos",    32'(rob_bus.store_rob_pos), 32'd0);
        chk("st_nocmt",  32'(rob_bus.rob_commit), 32'd0);
        step();
        chk("bp_commit", 32'(rob_bus.br_commit), 32'd1);
        chk("bp_taken",  32'(rob_bus.br_taken), 32'd1);
        chk("bp_no_rb",  32'(rob_bus.rollback), 32'd0);

        // fill to 15, then commit+issue together with tail wrap
        do_reset();
        for (int i = 0; i < 14; i++) issue_one(2'd0, 5'd1, 32'(i * 4), 1'b0, 1'b0, 32'h0);
        chk("full_14", 32'(rob_bus.rob_full), 32'd0);
        issue_one(2'd0, 5'd1, 32'h38, 1'b0, 1'b0, 32'h0);
        chk("full_15",  32'(rob_bus.rob_full), 32'd1);
        chk("tail_15",  32'(rob_bus.issue_rob_pos), 32'd15);
        alu_wb(4'd0, 32'h55, 1'b0, 32'h0);
        issue_one(2'd0, 5'd9, 32'h3c, 1'b0, 1'b0, 32'h0);
        chk("wrap_commit", 32'(rob_bus.rob_commit), 32'd1);
        chk("wrap_val",    rob_bus.rob_commit_val, 32'h55);
        chk("wrap_count",  32'(dut.count_q), 32'd15);
        chk("wrap_tail",   32'(rob_bus.issue_rob_pos), 32'd0);
        chk("wrap_full",   32'(rob_bus.rob_full), 32'd1);

        // jalr commit, with rdy freezing state and held pulses
        do_reset();
        issue_one(2'd3, 5'd1, 32'h40, 1'b0, 1'b0, 32'h0);
        alu_wb(4'd0, 32'h44, 1'b1, 32'h80);
        rob_bus.rdy = 1'b0;
        step();
        step();
        chk("frz_nocommit", 32'(rob_bus.rob_commit), 32'd0);
        chk("frz_count",    32'(dut.count_q), 32'd1);
        rob_bus.rdy = 1'b1;
        step();
        chk("jalr_commit", 32'(rob_bus.rob_commit), 32'd1);
        chk("jalr_rd",     32'(rob_bus.rob_commit_rd), 32'd1);
        chk("jalr_val",    rob_bus.rob_commit_val, 32'h44);
        chk("jalr_rb",     32'(rob_bus.rollback), 32'd1);
        chk("jalr_setpc",  rob_bus.set_pc, 32'h80);
        rob_bus.rdy = 1'b0;
        step();
        chk("frz_rb_hold",  32'(rob_bus.rollback), 32'd1);
        chk("frz_cmt_hold", 32'(rob_bus.rob_commit), 32'd1);
        rob_bus.rdy = 1'b1;
        step();
        chk("jalr_rb_drop",  32'(rob_bus.rollback), 32'd0);
        chk("jalr_cmt_drop", 32'(rob_bus.rob_commit), 32'd0);
        chk("jalr_count",    32'(dut.count_q), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
